// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: FSM state encoding,
// the IF/ID register payload, the halt opcode and the sequential PC step.
package fetch_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      HALTING = 2'd1,
      HALTED  = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] pc_plus2;
      logic [15:0] instr;
      logic        pred_taken;
      logic [15:0] pred_target;
      logic        valid;
   } ifid_t;

   localparam logic [3:0]  HLT_OPCODE = 4'hF;
   localparam logic [15:0] PC_STEP    = 16'd2;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register. Bubble (all zero) beats load, load beats hold.
// Synchronous active-high reset clears the whole payload.
module ifid_reg
   import fetch_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  load,
   input  logic  bubble,
   input  ifid_t d,
   output ifid_t q
);

   // Payload register: reset/bubble clear it, load captures, otherwise hold
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of process ordering.
      if (rst || bubble) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC generator and IF/ID register. Selects the next PC from
// redirect, hold, predicted target or PC+2, and runs the RUN/HALTING/HALTED
// halt sequencer. Optional saturating perf counters are built when the
// macro FETCH_PERF_CNT_EN is defined.
module fetch_pc_unit #(
   parameter int unsigned IDX_W      = 4,
   parameter logic [15:0] RESET_PC   = 16'h0000,
   parameter logic [3:0]  HLT_OPCODE = fetch_pkg::HLT_OPCODE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             mispredicted,
   input  logic [15:0]      redirect_pc,
   input  logic             pred_taken,
   input  logic [15:0]      pred_target,
   input  logic [15:0]      instr_in,
   output logic [15:0]      pc_curr,
   output logic [IDX_W-1:0] pc_index,
   output logic             dbp_enable,
   output logic [15:0]      if_id_pc,
   output logic [15:0]      if_id_pc_plus2,
   output logic [15:0]      if_id_instr,
   output logic             if_id_pred_taken,
   output logic [15:0]      if_id_pred_target,
   output logic             if_id_valid,
   output logic             halted
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [15:0]      fetch_cnt,
   output logic [15:0]      redirect_cnt
`endif
);

   import fetch_pkg::*;

   fetch_state_t state, state_next;
   logic [15:0]  pc_next;
   logic [15:0]  pc_plus2;
   logic         use_pred;
   logic         is_hlt;
   logic         ifid_load;
   logic         ifid_bubble;
   ifid_t        ifid_d;
   ifid_t        ifid_q;

   assign pc_plus2 = pc_curr + PC_STEP;
   // A misaligned predicted target cannot be fetched, so fall back to PC+2.
   assign use_pred = pred_taken & ~pred_target[0];
   assign is_hlt   = (instr_in[15:12] == HLT_OPCODE);
   assign pc_index = pc_curr[IDX_W:1];

   assign dbp_enable = (state == RUN) & ~stall & ~mispredicted & ~rst;

   // Next PC, next state and IF/ID control, highest priority first
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a variable unassigned and no latch is inferred.
      pc_next     = pc_curr;
      state_next  = state;
      ifid_load   = 1'b0;
      ifid_bubble = 1'b0;
      if (mispredicted) begin
         // Redirect wins over stall and halt; an older branch in ID
         // mispredicting also cancels a pending halt.
         pc_next     = redirect_pc;
         ifid_bubble = 1'b1;
         if (state == HALTING) begin
            state_next = RUN;
         end
      end else if (state == HALTING) begin
         if (!stall) begin
            ifid_bubble = 1'b1;
            state_next  = HALTED;
         end
      end else if (state == HALTED) begin
         ifid_bubble = 1'b1;
      end else if (!stall) begin
         ifid_load = 1'b1;
         if (is_hlt) begin
            state_next = HALTING;
         end else if (use_pred) begin
            pc_next = pred_target;
         end else begin
            pc_next = pc_plus2;
         end
      end
   end

   // PC, FSM state and halted flag registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_curr <= RESET_PC;
         state   <= RUN;
         halted  <= 1'b0;
      end else begin
         pc_curr <= pc_next;
         state   <= state_next;
         halted  <= (state_next == HALTED);
      end
   end

   assign ifid_d = '{
      pc:          pc_curr,
      pc_plus2:    pc_plus2,
      instr:       instr_in,
      pred_taken:  use_pred,
      pred_target: pred_target,
      valid:       1'b1
   };

   ifid_reg u_ifid_reg (
      .clk    (clk),
      .rst    (rst),
      .load   (ifid_load),
      .bubble (ifid_bubble),
      .d      (ifid_d),
      .q      (ifid_q)
   );

   assign if_id_pc          = ifid_q.pc;
   assign if_id_pc_plus2    = ifid_q.pc_plus2;
   assign if_id_instr       = ifid_q.instr;
   assign if_id_pred_taken  = ifid_q.pred_taken;
   assign if_id_pred_target = ifid_q.pred_target;
   assign if_id_valid       = ifid_q.valid;

`ifdef FETCH_PERF_CNT_EN
   // Saturating counters of accepted fetches and redirects
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt    <= '0;
         redirect_cnt <= '0;
      end else begin
         if (ifid_load && (fetch_cnt != 16'hFFFF)) begin
            fetch_cnt <= fetch_cnt + 16'd1;
         end
         if (mispredicted && (redirect_cnt != 16'hFFFF)) begin
            redirect_cnt <= redirect_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios followed by a
// randomized run against a behavioural model of the fetch rules.
module tb_fetch_pc_unit;

   localparam int          IDX_W = 4;
   localparam logic [3:0]  HLT   = 4'hF;

   logic             clk = 1'b0;
   logic             rst, stall, mispredicted, pred_taken;
   logic [15:0]      redirect_pc, pred_target, instr_in;
   logic [15:0]      pc_curr;
   logic [IDX_W-1:0] pc_index;
   logic             dbp_enable;
   logic [15:0]      if_id_pc, if_id_pc_plus2, if_id_instr, if_id_pred_target;
   logic             if_id_pred_taken, if_id_valid, halted;
`ifdef FETCH_PERF_CNT_EN
   logic [15:0]      fetch_cnt, redirect_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   fetch_pc_unit #(.IDX_W(IDX_W), .RESET_PC(16'h0000), .HLT_OPCODE(4'hF)) dut (
      .clk               (clk),
      .rst               (rst),
      .stall             (stall),
      .mispredicted      (mispredicted),
      .redirect_pc       (redirect_pc),
      .pred_taken        (pred_taken),
      .pred_target       (pred_target),
      .instr_in          (instr_in),
      .pc_curr           (pc_curr),
      .pc_index          (pc_index),
      .dbp_enable        (dbp_enable),
      .if_id_pc          (if_id_pc),
      .if_id_pc_plus2    (if_id_pc_plus2),
      .if_id_instr       (if_id_instr),
      .if_id_pred_taken  (if_id_pred_taken),
      .if_id_pred_target (if_id_pred_target),
      .if_id_valid       (if_id_valid),
      .halted            (halted)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_cnt         (fetch_cnt),
      .redirect_cnt      (redirect_cnt)
`endif
   );

   // Advance one clock and settle just past the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rst          = 1'b0;
      stall        = 1'b0;
      mispredicted = 1'b0;
      redirect_pc  = 16'h0000;
      pred_taken   = 1'b0;
      pred_target  = 16'h0000;
      instr_in     = 16'h1234;
   endtask

   task automatic redirect_to(input logic [15:0] pc);
      mispredicted = 1'b1;
      redirect_pc  = pc;
      tick();
      mispredicted = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      n_tests++;
      if ({pc_curr, if_id_valid, halted, dbp_enable} !== {16'h0000, 1'b0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_state: got pc=%h v=%b h=%b en=%b, expected pc=0000 v=0 h=0 en=0",
                  pc_curr, if_id_valid, halted, dbp_enable);
      end
      n_tests++;
      if ({if_id_pc, if_id_instr, if_id_pred_target, if_id_pred_taken} !== 49'd0) begin
         n_fail++;
         $display("FAIL reset_ifid: got pc=%h instr=%h tgt=%h tk=%b, expected all zero",
                  if_id_pc, if_id_instr, if_id_pred_target, if_id_pred_taken);
      end
      rst = 1'b0;
      #1;
      n_tests++;
      if (dbp_enable !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_enable: got %b, expected 1", dbp_enable);
      end
   endtask

   task automatic test_sequential();
      idle_inputs();
      for (int i = 1; i <= 3; i++) begin
         tick();
         n_tests++;
         if ({pc_curr, if_id_pc, if_id_pc_plus2, if_id_valid} !==
             {16'(2 * i), 16'(2 * (i - 1)), 16'(2 * i), 1'b1}) begin
            n_fail++;
            $display("FAIL seq_step%0d: got pc=%h ifpc=%h ifpc2=%h v=%b, expected pc=%h ifpc=%h ifpc2=%h v=1",
                     i, pc_curr, if_id_pc, if_id_pc_plus2, if_id_valid,
                     16'(2 * i), 16'(2 * (i - 1)), 16'(2 * i));
         end
      end
      redirect_to(16'hFFFE);
      n_tests++;
      if ({pc_curr, if_id_valid} !== {16'hFFFE, 1'b0}) begin
         n_fail++;
         $display("FAIL seq_redirect_fffe: got pc=%h v=%b, expected pc=fffe v=0", pc_curr, if_id_valid);
      end
      tick();
      n_tests++;
      if ({pc_curr, if_id_pc, if_id_pc_plus2} !== {16'h0000, 16'hFFFE, 16'h0000}) begin
         n_fail++;
         $display("FAIL seq_wrap: got pc=%h ifpc=%h ifpc2=%h, expected pc=0000 ifpc=fffe ifpc2=0000",
                  pc_curr, if_id_pc, if_id_pc_plus2);
      end
   endtask

   task automatic test_pred_taken();
      idle_inputs();
      redirect_to(16'h0004);
      pred_taken  = 1'b1;
      pred_target = 16'h0040;
      tick();
      n_tests++;
      if ({pc_curr, if_id_pc, if_id_pred_taken, if_id_pred_target} !== {16'h0040, 16'h0004, 1'b1, 16'h0040}) begin
         n_fail++;
         $display("FAIL pred_taken: got pc=%h ifpc=%h tk=%b tgt=%h, expected pc=0040 ifpc=0004 tk=1 tgt=0040",
                  pc_curr, if_id_pc, if_id_pred_taken, if_id_pred_target);
      end
      pred_taken = 1'b0;
      redirect_to(16'h0004);
      pred_taken  = 1'b1;
      pred_target = 16'h0041;
      tick();
      n_tests++;
      if ({pc_curr, if_id_pred_taken, if_id_pred_target} !== {16'h0006, 1'b0, 16'h0041}) begin
         n_fail++;
         $display("FAIL pred_misaligned: got pc=%h tk=%b tgt=%h, expected pc=0006 tk=0 tgt=0041",
                  pc_curr, if_id_pred_taken, if_id_pred_target);
      end
   endtask

   task automatic test_mispredict_stall();
      idle_inputs();
      stall        = 1'b1;
      mispredicted = 1'b1;
      redirect_pc  = 16'h0080;
      #1;
      n_tests++;
      if (dbp_enable !== 1'b0) begin
         n_fail++;
         $display("FAIL mispred_enable: got %b, expected 0", dbp_enable);
      end
      tick();
      n_tests++;
      if ({pc_curr, if_id_valid} !== {16'h0080, 1'b0}) begin
         n_fail++;
         $display("FAIL mispred_stall: got pc=%h v=%b, expected pc=0080 v=0", pc_curr, if_id_valid);
      end
      mispredicted = 1'b0;
      stall        = 1'b0;
      tick();
      stall = 1'b1;
      tick();
      tick();
      n_tests++;
      if ({pc_curr, if_id_pc, if_id_valid} !== {16'h0082, 16'h0080, 1'b1}) begin
         n_fail++;
         $display("FAIL stall_hold: got pc=%h ifpc=%h v=%b, expected pc=0082 ifpc=0080 v=1",
                  pc_curr, if_id_pc, if_id_valid);
      end
      stall = 1'b0;
   endtask

   task automatic test_halt();
      idle_inputs();
      redirect_to(16'h000A);
      instr_in = 16'hF000;
      stall    = 1'b1;
      tick();
      n_tests++;
      if ({pc_curr, halted, dbp_enable} !== {16'h000A, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL halt_stalled: got pc=%h h=%b en=%b, expected pc=000a h=0 en=0",
                  pc_curr, halted, dbp_enable);
      end
      stall = 1'b0;
      #1;
      n_tests++;
      if (dbp_enable !== 1'b1) begin
         n_fail++;
         $display("FAIL halt_refetch_enable: got %b, expected 1", dbp_enable);
      end
      tick();
      n_tests++;
      if ({pc_curr, if_id_instr, if_id_valid, halted, dbp_enable} !== {16'h000A, 16'hF000, 1'b1, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL halt_load: got pc=%h instr=%h v=%b h=%b en=%b, expected pc=000a instr=f000 v=1 h=0 en=0",
                  pc_curr, if_id_instr, if_id_valid, halted, dbp_enable);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++;
         if ({pc_curr, if_id_valid, halted} !== {16'h000A, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL halted_cycle%0d: got pc=%h v=%b h=%b, expected pc=000a v=0 h=1",
                     i, pc_curr, if_id_valid, halted);
         end
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_tests++;
      if ({pc_curr, halted} !== {16'h0000, 1'b0}) begin
         n_fail++;
         $display("FAIL halt_reset: got pc=%h h=%b, expected pc=0000 h=0", pc_curr, halted);
      end
   endtask

   task automatic test_halt_squash();
      idle_inputs();
      instr_in     = 16'hF000;
      mispredicted = 1'b1;
      redirect_pc  = 16'h0020;
      tick();
      mispredicted = 1'b0;
      instr_in     = 16'h1234;
      n_tests++;
      if ({pc_curr, if_id_valid, halted} !== {16'h0020, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL squash_redirect: got pc=%h v=%b h=%b, expected pc=0020 v=0 h=0",
                  pc_curr, if_id_valid, halted);
      end
      tick();
      n_tests++;
      if ({pc_curr, if_id_valid, halted} !== {16'h0022, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL squash_resume: got pc=%h v=%b h=%b, expected pc=0022 v=1 h=0",
                  pc_curr, if_id_valid, halted);
      end
      // Halt loaded, then the older branch in ID mispredicts: back to RUN.
      instr_in = 16'hF123;
      tick();
      instr_in = 16'h1234;
      redirect_to(16'h0030);
      tick();
      n_tests++;
      if ({pc_curr, if_id_pc, if_id_valid, halted} !== {16'h0032, 16'h0030, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL halting_cancel: got pc=%h ifpc=%h v=%b h=%b, expected pc=0032 ifpc=0030 v=1 h=0",
                  pc_curr, if_id_pc, if_id_valid, halted);
      end
   endtask

   // Randomized run against a rule-level model of fetch.
   task automatic test_random();
      logic [15:0] m_pc, m_ipc, m_ipc2, m_instr, m_tgt;
      logic        m_taken, m_valid;
      int          m_mode;   // 0 running, 1 halt in IF/ID, 2 halted
      logic        taken_eff, exp_en;
      int          m_fetches, m_redirects;

      idle_inputs();
      rst = 1'b1;
      tick();
      m_pc = 16'h0000; m_mode = 0; m_valid = 1'b0;
      {m_ipc, m_ipc2, m_instr, m_taken, m_tgt} = '0;
      m_fetches = 0; m_redirects = 0;

      for (int c = 0; c < 800; c++) begin
         rst          = ($urandom_range(99) < 3);
         stall        = ($urandom_range(99) < 25);
         mispredicted = ($urandom_range(99) < 12);
         redirect_pc  = 16'($urandom) & 16'hFFFE;
         pred_taken   = ($urandom_range(99) < 35);
         pred_target  = 16'($urandom);
         instr_in     = 16'($urandom);
         if ($urandom_range(99) < 8) instr_in[15:12] = HLT;
         else if (instr_in[15:12] == HLT) instr_in[15:12] = 4'h0;
         #1;
         exp_en = !rst && (m_mode == 0) && !stall && !mispredicted;
         n_tests++;
         if (dbp_enable !== exp_en) begin
            n_fail++;
            $display("FAIL rnd_enable c=%0d: got %b, expected %b", c, dbp_enable, exp_en);
         end

         taken_eff = pred_taken && (pred_target % 2 == 0);
         if (rst) begin
            m_pc = 16'h0000; m_mode = 0; m_valid = 1'b0;
            {m_ipc, m_ipc2, m_instr, m_taken, m_tgt} = '0;
            m_fetches = 0; m_redirects = 0;
         end else if (mispredicted) begin
            m_pc = redirect_pc;
            m_valid = 1'b0;
            {m_ipc, m_ipc2, m_instr, m_taken, m_tgt} = '0;
            if (m_mode == 1) m_mode = 0;
            if (m_redirects < 65535) m_redirects++;
         end else if (m_mode == 2 || (m_mode == 1 && !stall)) begin
            m_valid = 1'b0;
            {m_ipc, m_ipc2, m_instr, m_taken, m_tgt} = '0;
            m_mode = 2;
         end else if (m_mode == 0 && !stall) begin
            m_ipc   = m_pc;
            m_ipc2  = m_pc + 16'd2;
            m_instr = instr_in;
            m_taken = taken_eff;
            m_tgt   = pred_target;
            m_valid = 1'b1;
            if (m_fetches < 65535) m_fetches++;
            if (instr_in[15:12] == HLT) m_mode = 1;
            else m_pc = taken_eff ? pred_target : m_pc + 16'd2;
         end

         tick();
         n_tests++;
         if ({pc_curr, pc_index, halted} !== {m_pc, IDX_W'(m_pc >> 1), (m_mode == 2)}) begin
            n_fail++;
            $display("FAIL rnd_pc c=%0d: got pc=%h idx=%h h=%b, expected pc=%h idx=%h h=%b",
                     c, pc_curr, pc_index, halted, m_pc, IDX_W'(m_pc >> 1), (m_mode == 2));
         end
         n_tests++;
         if ({if_id_pc, if_id_pc_plus2, if_id_instr, if_id_pred_taken, if_id_pred_target, if_id_valid} !==
             {m_ipc, m_ipc2, m_instr, m_taken, m_tgt, m_valid}) begin
            n_fail++;
            $display("FAIL rnd_ifid c=%0d: got %h/%h/%h/%b/%h/%b, expected %h/%h/%h/%b/%h/%b", c,
                     if_id_pc, if_id_pc_plus2, if_id_instr, if_id_pred_taken, if_id_pred_target, if_id_valid,
                     m_ipc, m_ipc2, m_instr, m_taken, m_tgt, m_valid);
         end
`ifdef FETCH_PERF_CNT_EN
         n_tests++;
         if ({fetch_cnt, redirect_cnt} !== {16'(m_fetches), 16'(m_redirects)}) begin
            n_fail++;
            $display("FAIL rnd_perf c=%0d: got fetch=%0d redir=%0d, expected fetch=%0d redir=%0d",
                     c, fetch_cnt, redirect_cnt, m_fetches, m_redirects);
         end
`endif
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      @(negedge clk);
      test_reset();
      test_sequential();
      test_pred_taken();
      test_mispredict_stall();
      test_halt();
      test_halt_squash();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
